// File: rtl/aes_key_sched_iter_if.sv
// Key-schedule control/readback bus: start request, key load, status and
// round-key read port between the key loader/cipher core and the expander.
interface aes_key_sched_iter_if;
  logic         start;
  logic [1:0]   key_size;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         err;
  logic         key_valid;
  logic [3:0]   num_rounds;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  modport master (
    output start, key_size, key, rd_round,
    input  busy, done, err, key_valid, num_rounds, rd_key
  );

  modport slave (
    input  start, key_size, key, rd_round,
    output busy, done, err, key_valid, num_rounds, rd_key
  );
endinterface

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128/192/256 key schedule. Loads Nk key words in one cycle,
// then produces one schedule word per clock through a single shared SubWord
// into a word store; any round key is read back combinationally by index.
module aes_key_sched_iter #(
  parameter int unsigned MAX_NK = 8,
  parameter int unsigned WORDS  = 4 * (MAX_NK + 7)
) (
  input logic clk,
  input logic rst,
  aes_key_sched_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_nk;
  logic [3:0]  r_nr;
  logic [5:0]  r_i;
  logic [2:0]  r_mod;
  logic [7:0]  r_rcon;
  logic        r_done;
  logic        r_err;
  logic        r_valid;
  logic [31:0] r_store [WORDS];

  logic [3:0]  w_req_nk;
  logic        w_legal;
  logic        w_accept;
  logic        w_reject;
  logic        w_last;
  logic [5:0]  w_last_idx;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_sub;
  logic [31:0] w_temp;
  logic [31:0] w_new;
  logic [5:0]  w_rd_base;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = a;
    for (int unsigned n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254, zero maps to zero) followed by
  // the affine transform, so no 256-entry table is needed per lane.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] inv;
    s   = a;
    inv = 8'h01;
    for (int unsigned n = 1; n < 8; n++) begin
      s   = gf_mul(s, s);
      inv = gf_mul(inv, s);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned b = 0; b < 4; b++) y[8*b +: 8] = sbox(x[8*b +: 8]);
    return y;
  endfunction

  // Decode requested size and legality against MAX_NK.
  always_comb begin
    w_req_nk = 4'd0;
    case (bus.key_size)
      2'b00:   w_req_nk = 4'd4;
      2'b01:   w_req_nk = 4'd6;
      2'b10:   w_req_nk = 4'd8;
      default: w_req_nk = 4'd0;
    endcase
  end

  assign w_legal    = (w_req_nk != 4'd0) && (32'(w_req_nk) <= MAX_NK);
  assign w_last_idx = {r_nr + 4'd1, 2'b00} - 6'd1;
  assign w_last     = (r_state == EXPAND) && (r_i == w_last_idx);

  // Next-state and start accept/reject strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_legal) begin
            w_accept    = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      LOAD:    w_state_nxt = EXPAND;
      EXPAND:  if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Size latch, word counter, i mod Nk wrap counter, Rcon and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nk    <= '0;
      r_nr    <= '0;
      r_i     <= '0;
      r_mod   <= '0;
      r_rcon  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_reject;
      if (w_accept) begin
        r_nk    <= w_req_nk;
        r_nr    <= w_req_nk + 4'd6;
        r_valid <= 1'b0;
      end
      if (r_state == LOAD) begin
        r_i    <= {2'b00, r_nk};
        r_mod  <= '0;
        r_rcon <= 8'h01;
      end
      if (r_state == EXPAND) begin
        r_i   <= r_i + 6'd1;
        r_mod <= ({1'b0, r_mod} == r_nk - 4'd1) ? 3'd0 : r_mod + 3'd1;
        if (r_mod == 3'd0) r_rcon <= xtime(r_rcon);
        if (w_last) begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign w_prev = r_store[r_i - 6'd1];
  assign w_back = r_store[r_i - {2'b00, r_nk}];
  assign w_sub  = sub_word(w_prev);

  // Recurrence term; SubWord is bytewise so rotating after it equals
  // SubWord(RotWord(x)), letting one SubWord serve both cases.
  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0)
      w_temp = {w_sub[23:0], w_sub[31:24]} ^ {r_rcon, 24'h000000};
    else if (r_nk == 4'd8 && r_mod == 3'd4)
      w_temp = w_sub;
  end

  assign w_new = w_back ^ w_temp;

  // Word store: bulk key load in LOAD, one expanded word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (r_state == LOAD) begin
      for (int unsigned j = 0; j < MAX_NK; j++) begin
        if (j < 32'(r_nk)) r_store[6'(j)] <= bus.key[255 - 32*j -: 32];
      end
    end else if (r_state == EXPAND) begin
      r_store[r_i] <= w_new;
    end
  end

  assign w_rd_base = {bus.rd_round, 2'b00};

  // Round-key readback, zero when no valid schedule or index beyond Nr.
  always_comb begin
    bus.rd_key = '0;
    if (r_valid && (bus.rd_round <= r_nr))
      bus.rd_key = {r_store[w_rd_base],         r_store[w_rd_base + 6'd1],
                    r_store[w_rd_base + 6'd2],  r_store[w_rd_base + 6'd3]};
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.key_valid  = r_valid;
  assign bus.num_rounds = r_nr;

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Bench for aes_key_sched_iter: FIPS-197 vectors plus random keys checked
// against a table-driven key-expansion model.
module tb_aes_key_sched_iter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0]   sb   [256];
  logic [127:0] m_rk [16];
  int           m_nk;
  int           m_nr;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_sched_iter_if bus_if();

  aes_key_sched_iter #(.MAX_NK(8), .WORDS(60)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // S-box from the generator-3 log walk with the affine map.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    sb[0] = 8'h63;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
  endtask

  function automatic logic [31:0] m_sub(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  // Reference key expansion straight from the FIPS-197 pseudo-code.
  task automatic model_expand(input logic [1:0] ks, input logic [255:0] k);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    m_nk = 4 + 2 * int'(ks);
    m_nr = m_nk + 6;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < m_nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
      t = w[i-1];
      if (i % m_nk == 0)
        t = m_sub({t[23:0], t[31:24]}) ^ {rc[i/m_nk - 1], 24'h0};
      else if (m_nk > 6 && i % m_nk == 4)
        t = m_sub(t);
      w[i] = w[i-m_nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      m_rk[r] = (r <= m_nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Issue one start and wait (bounded) for done; lat = -1 on timeout.
  task automatic run_key(input logic [1:0] ks, input logic [255:0] k, output int lat);
    bus_if.key_size = ks;
    bus_if.key      = k;
    bus_if.start    = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    lat = 1;
    while (bus_if.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus_if.done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.key_size = 2'b00; bus_if.key = '0; bus_if.rd_round = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus_if.busy); end
    n_checks++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", bus_if.done); end
    n_checks++; if (bus_if.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", bus_if.err); end
    n_checks++; if (bus_if.key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus_if.key_valid); end
    n_checks++; if (bus_if.num_rounds !== 4'd0) begin n_fail++; $display("FAIL rst_nr: got %0d expected 0", bus_if.num_rounds); end
    n_checks++; if (bus_if.rd_key !== 128'h0) begin n_fail++; $display("FAIL rst_rdkey: got %h expected 0", bus_if.rd_key); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_aes128();
    int lat;
    run_key(2'b00, K128, lat);
    model_expand(2'b00, K128);
    n_checks++; if (lat != 42) begin n_fail++; $display("FAIL aes128_latency: got %0d expected 42", lat); end
    n_checks++; if (bus_if.num_rounds !== 4'd10) begin n_fail++; $display("FAIL aes128_nr: got %0d expected 10", bus_if.num_rounds); end
    n_checks++; if (bus_if.key_valid !== 1'b1 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL aes128_status: got valid=%b busy=%b expected valid=1 busy=0", bus_if.key_valid, bus_if.busy); end
    bus_if.rd_round = 4'd1; #1;
    n_checks++; if (bus_if.rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_fail++; $display("FAIL aes128_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", bus_if.rd_key); end
    bus_if.rd_round = 4'd10; #1;
    n_checks++; if (bus_if.rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL aes128_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", bus_if.rd_key); end
    for (int r = 0; r < 16; r++) begin
      bus_if.rd_round = 4'(r); #1;
      n_checks++; if (bus_if.rd_key !== m_rk[r]) begin n_fail++; $display("FAIL aes128_model_rk%0d: got %h expected %h", r, bus_if.rd_key, m_rk[r]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_aes192();
    int lat;
    run_key(2'b01, K192, lat);
    model_expand(2'b01, K192);
    n_checks++; if (lat != 48) begin n_fail++; $display("FAIL aes192_latency: got %0d expected 48", lat); end
    n_checks++; if (bus_if.num_rounds !== 4'd12) begin n_fail++; $display("FAIL aes192_nr: got %0d expected 12", bus_if.num_rounds); end
    bus_if.rd_round = 4'd12; #1;
    n_checks++; if (bus_if.rd_key !== 128'he98ba06f448c773c8ecc720401002202) begin n_fail++; $display("FAIL aes192_rk12: got %h expected e98ba06f448c773c8ecc720401002202", bus_if.rd_key); end
    for (int r = 0; r < 16; r++) begin
      bus_if.rd_round = 4'(r); #1;
      n_checks++; if (bus_if.rd_key !== m_rk[r]) begin n_fail++; $display("FAIL aes192_model_rk%0d: got %h expected %h", r, bus_if.rd_key, m_rk[r]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_aes256();
    int lat;
    run_key(2'b10, K256, lat);
    model_expand(2'b10, K256);
    n_checks++; if (lat != 54) begin n_fail++; $display("FAIL aes256_latency: got %0d expected 54", lat); end
    n_checks++; if (bus_if.num_rounds !== 4'd14) begin n_fail++; $display("FAIL aes256_nr: got %0d expected 14", bus_if.num_rounds); end
    bus_if.rd_round = 4'd14; #1;
    n_checks++; if (bus_if.rd_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin n_fail++; $display("FAIL aes256_rk14: got %h expected fe4890d1e6188d0b046df344706c631e", bus_if.rd_key); end
    bus_if.rd_round = 4'd15; #1;
    n_checks++; if (bus_if.rd_key !== 128'h0) begin n_fail++; $display("FAIL aes256_rk15: got %h expected 0", bus_if.rd_key); end
    for (int r = 0; r < 16; r++) begin
      bus_if.rd_round = 4'(r); #1;
      n_checks++; if (bus_if.rd_key !== m_rk[r]) begin n_fail++; $display("FAIL aes256_model_rk%0d: got %h expected %h", r, bus_if.rd_key, m_rk[r]); end
    end
    @(posedge clk); #1;
  endtask

  // Relies on the AES-256 schedule from the previous task being valid.
  task automatic test_illegal();
    bus_if.key_size = 2'b11;
    bus_if.start    = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n_checks++; if (bus_if.err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b expected 1", bus_if.err); end
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL illegal_busy: got %b expected 0", bus_if.busy); end
    n_checks++; if (bus_if.key_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_valid: got %b expected 1", bus_if.key_valid); end
    n_checks++; if (bus_if.num_rounds !== 4'(m_nr)) begin n_fail++; $display("FAIL illegal_nr: got %0d expected %0d", bus_if.num_rounds, m_nr); end
    @(posedge clk); #1;
    n_checks++; if (bus_if.err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse: got %b expected 0", bus_if.err); end
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL illegal_busy_after: got %b expected 0", bus_if.busy); end
    bus_if.rd_round = 4'(m_nr); #1;
    n_checks++; if (bus_if.rd_key !== m_rk[m_nr]) begin n_fail++; $display("FAIL illegal_rk_kept: got %h expected %h", bus_if.rd_key, m_rk[m_nr]); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    logic [255:0] ka;
    logic [255:0] kb;
    int n;
    for (int b = 0; b < 8; b++) begin ka[32*b +: 32] = $urandom; kb[32*b +: 32] = $urandom; end
    bus_if.key_size = 2'b00; bus_if.key = ka; bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n = 1;
    while (bus_if.done !== 1'b1 && n < 200) begin
      if (n == 20) begin bus_if.start = 1'b1; bus_if.key_size = 2'b10; bus_if.key = kb; end
      @(posedge clk); #1;
      n++;
      if (n == 21) begin
        bus_if.start = 1'b0;
        n_checks++; if (bus_if.err !== 1'b0) begin n_fail++; $display("FAIL busy_start_err: got %b expected 0", bus_if.err); end
        n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_busy: got %b expected 1", bus_if.busy); end
      end
    end
    model_expand(2'b00, ka);
    n_checks++; if (n != 42) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 42", n); end
    n_checks++; if (bus_if.num_rounds !== 4'd10) begin n_fail++; $display("FAIL busy_start_nr: got %0d expected 10", bus_if.num_rounds); end
    for (int r = 0; r < 16; r++) begin
      bus_if.rd_round = 4'(r); #1;
      n_checks++; if (bus_if.rd_key !== m_rk[r]) begin n_fail++; $display("FAIL busy_start_rk%0d: got %h expected %h", r, bus_if.rd_key, m_rk[r]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [255:0] ka;
    logic [255:0] kb;
    logic [1:0]   sa;
    logic [1:0]   sbz;
    int lat;
    int n;
    for (int b = 0; b < 8; b++) begin ka[32*b +: 32] = $urandom; kb[32*b +: 32] = $urandom; end
    sa  = 2'($urandom_range(0, 2));
    sbz = 2'($urandom_range(0, 2));
    run_key(sa, ka, lat);
    n_checks++; if (lat != 2 + 4 * (4 + 2 * int'(sa) + 7) - (4 + 2 * int'(sa))) begin n_fail++; $display("FAIL b2b_first_latency: got %0d", lat); end
    bus_if.key_size = sbz; bus_if.key = kb; bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n_checks++; if (bus_if.key_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b expected 0", bus_if.key_valid); end
    n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", bus_if.busy); end
    n = 1;
    while (bus_if.done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    model_expand(sbz, kb);
    n_checks++; if (n != 2 + 4 * (m_nr + 1) - m_nk) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", n, 2 + 4 * (m_nr + 1) - m_nk); end
    for (int r = 0; r < 16; r++) begin
      bus_if.rd_round = 4'(r); #1;
      n_checks++; if (bus_if.rd_key !== m_rk[r]) begin n_fail++; $display("FAIL b2b_rk%0d: got %h expected %h", r, bus_if.rd_key, m_rk[r]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    logic [255:0] k;
    int n;
    int lat;
    for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom;
    bus_if.key_size = 2'b10; bus_if.key = k; bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n = 1;
    while (n < 10) begin @(posedge clk); #1; n++; end
    bus_if.rd_round = 4'd0;
    rst = 1'b1;
    #1;
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus_if.busy); end
    n_checks++; if (bus_if.key_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", bus_if.key_valid); end
    n_checks++; if (bus_if.rd_key !== 128'h0) begin n_fail++; $display("FAIL midrst_rdkey: got %h expected 0", bus_if.rd_key); end
    n_checks++; if (bus_if.num_rounds !== 4'd0) begin n_fail++; $display("FAIL midrst_nr: got %0d expected 0", bus_if.num_rounds); end
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_resume: got busy=%b done=%b expected 0 0", bus_if.busy, bus_if.done); end
    run_key(2'b00, K128, lat);
    n_checks++; if (lat != 42) begin n_fail++; $display("FAIL midrst_rerun_latency: got %0d expected 42", lat); end
    bus_if.rd_round = 4'd10; #1;
    n_checks++; if (bus_if.rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL midrst_rerun_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", bus_if.rd_key); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [255:0] k;
    logic [1:0]   ks;
    int lat;
    for (int t = 0; t < 8; t++) begin
      for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom;
      ks = 2'($urandom_range(0, 2));
      run_key(ks, k, lat);
      model_expand(ks, k);
      n_checks++; if (lat != 2 + 4 * (m_nr + 1) - m_nk) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, lat, 2 + 4 * (m_nr + 1) - m_nk); end
      n_checks++; if (bus_if.num_rounds !== 4'(m_nr)) begin n_fail++; $display("FAIL rand%0d_nr: got %0d expected %0d", t, bus_if.num_rounds, m_nr); end
      @(posedge clk); #1;
      n_checks++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL rand%0d_done_pulse: got %b expected 0", t, bus_if.done); end
      for (int r = 0; r < 16; r++) begin
        bus_if.rd_round = 4'(r); #1;
        n_checks++; if (bus_if.rd_key !== m_rk[r]) begin n_fail++; $display("FAIL rand%0d_rk%0d: got %h expected %h", t, r, bus_if.rd_key, m_rk[r]); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_illegal();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
